s2_rx: RTL and testbench

- Serial receiver at the far end of the sen/sd link driven by the S1 transmitter.
- Deserializes framed packets, each a 3-bit address followed by 18 data bits, both MSB first.
- Writes each completed 18-bit word into register bank RB2 at the received address.
- Asserts done after NUM_PKT words are stored.

---
 rtl/s2_pkg.sv | 27 ++
 rtl/s2_deser.sv | 79 +++++++
 rtl/s2_rx.sv | 148 ++++++++++++++
 tb/tb_s2_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/s2_pkg.sv
// Shared definitions for the S2 serial receiver: FSM state encoding,
// default geometry of the sen/sd frame, and a small saturating helper.
package s2_pkg;

    localparam int S2_ADDR_W    = 3;
    localparam int S2_DATA_W    = 18;
    localparam int S2_NUM_PKT   = 8;
    localparam int S2_FRAME_LEN = S2_ADDR_W + S2_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } s2_state_e;

    // Four-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'd15) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/s2_deser.sv
// Frame deserializer: shifts sd in MSB first while sen is low, counts bits,
// and flags the cycle in which the last bit of a frame is sampled. The
// address/data outputs are valid together with frame_valid_o and already
// include that last bit. Only the first FRAME_LEN-1 bits need storage; the
// final bit is taken straight from sd.
// Optional: S2_RX_ERR_EN adds abort_o, high when sen rises mid-frame.
module s2_deser
    import s2_pkg::*;
#(
    parameter int ADDR_W = S2_ADDR_W,
    parameter int DATA_W = S2_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              sen,
    input  logic              sd,
    output logic              frame_valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
`ifdef S2_RX_ERR_EN
    ,
    output logic              abort_o
`endif
);

    localparam int FRAME_LEN = ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    logic [FRAME_LEN-2:0] sr_q;
    logic [FRAME_LEN-1:0] sr_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 last_s;
    logic                 abort_s;

    // Next shift value, last-bit detection and bit counter update.
    always_comb begin
        sr_d    = {sr_q, sd};
        last_s  = 1'b0;
        abort_s = 1'b0;
        cnt_d   = cnt_q;
        if (!en_i) begin
            cnt_d = cnt_q;
        end else if (sen) begin
            // Gap between frames when the count is zero, otherwise an abort.
            abort_s = (cnt_q != '0);
            cnt_d   = '0;
        end else if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            last_s = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Shift register and bit counter state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (en_i && !sen) begin
                sr_q <= sr_d[FRAME_LEN-2:0];
            end else begin
                sr_q <= sr_q;
            end
        end
    end

    assign frame_valid_o = last_s;
    assign addr_o        = sr_d[FRAME_LEN-1 -: ADDR_W];
    assign data_o        = sr_d[DATA_W-1:0];
`ifdef S2_RX_ERR_EN
    assign abort_o       = abort_s;
`endif

endmodule

// File: rtl/s2_rx.sv
// S2 serial receiver top: deserializes sen/sd frames (address then data,
// MSB first) and writes each completed word into RB2 through a one-cycle
// write register, raising a sticky done after NUM_PKT writes.
// Optional: define S2_RX_ERR_EN to add frame_err (abort pulse) and err_cnt
// (saturating abort counter) outputs.
module s2_rx
    import s2_pkg::*;
#(
    parameter int ADDR_W  = S2_ADDR_W,
    parameter int DATA_W  = S2_DATA_W,
    parameter int NUM_PKT = S2_NUM_PKT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    output logic              done
`ifdef S2_RX_ERR_EN
    ,
    output logic              frame_err,
    output logic [3:0]        err_cnt
`endif
);

    localparam int PKT_W = $clog2(NUM_PKT + 1);

    s2_state_e         state_q;
    logic [PKT_W-1:0]  pkt_q;
    logic              rw_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic              done_q;

    logic              en_s;
    logic              frame_valid_s;
    logic [ADDR_W-1:0] frame_addr_s;
    logic [DATA_W-1:0] frame_data_s;
`ifdef S2_RX_ERR_EN
    logic              abort_s;
    logic              frame_err_q;
    logic [3:0]        err_cnt_q;
`endif

    // Once done the link is ignored entirely.
    assign en_s = (state_q != ST_DONE);

    s2_deser #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_deser (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_s),
        .sen           (sen),
        .sd            (sd),
        .frame_valid_o (frame_valid_s),
        .addr_o        (frame_addr_s),
        .data_o        (frame_data_s)
`ifdef S2_RX_ERR_EN
        ,
        .abort_o       (abort_s)
`endif
    );

    // Receive FSM, packet counter and RB2 write register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pkt_q   <= '0;
            rw_q    <= 1'b1;
            a_q     <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rw_q <= 1'b1;
                    if (!sen) begin
                        state_q <= ST_RECV;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (frame_valid_s) begin
                        // The next frame may start on this same edge; the
                        // write register is independent of the shifter.
                        rw_q  <= 1'b0;
                        a_q   <= frame_addr_s;
                        d_q   <= frame_data_s;
                        pkt_q <= pkt_q + PKT_W'(1);
                        if (pkt_q == PKT_W'(NUM_PKT - 1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RECV;
                        end
                    end else begin
                        rw_q <= 1'b1;
                        if (sen) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_RECV;
                        end
                    end
                end
                ST_DONE: begin
                    rw_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: begin
                    rw_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef S2_RX_ERR_EN
    // Abort pulse one cycle after a mid-frame sen rise, plus saturating count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err_q <= 1'b0;
            err_cnt_q   <= 4'd0;
        end else begin
            frame_err_q <= abort_s;
            if (abort_s) begin
                err_cnt_q <= sat_inc4(err_cnt_q);
            end else begin
                err_cnt_q <= err_cnt_q;
            end
        end
    end

    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
`endif

    assign RB2_RW = rw_q;
    assign RB2_A  = a_q;
    assign RB2_D  = d_q;
    assign done   = done_q;

endmodule

// File: tb/tb_s2_rx.sv
// Self-checking bench for s2_rx. A bit-level behavioural model predicts,
// for every clock, the RB2 write strobe, address, data and done flag from
// the frame rules: 21 consecutive sen-low bits form a frame whose value is
// addr*2^18+data; a sen rise with a partial frame discards it.
module tb_s2_rx;

    localparam int AW = 3;
    localparam int DW = 18;
    localparam int NP = 8;
    localparam int FL = AW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sen = 1'b1;
    logic          sd  = 1'b0;
    logic          RB2_RW;
    logic [AW-1:0] RB2_A;
    logic [DW-1:0] RB2_D;
    logic          done;
`ifdef S2_RX_ERR_EN
    logic          frame_err;
    logic [3:0]    err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model state.
    int            run;
    longint        acc;
    int            m_pkts;
    bit            m_done;
    logic          e_rw;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    logic          e_err;
    int            e_ecnt;

    always #5 clk = ~clk;

    s2_rx #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .NUM_PKT (NP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sen       (sen),
        .sd        (sd),
        .RB2_RW    (RB2_RW),
        .RB2_A     (RB2_A),
        .RB2_D     (RB2_D),
        .done      (done)
`ifdef S2_RX_ERR_EN
        ,
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply rst/sen/sd, advance the model, then compare outputs.
    task automatic step(input logic r, input logic s, input logic d);
        rst   = r;
        sen   = s;
        sd    = d;
        e_err = 1'b0;
        e_rw  = 1'b1;
        if (!r) begin
            e_a    = '0;
            e_d    = '0;
            m_done = 1'b0;
            m_pkts = 0;
            run    = 0;
            acc    = 0;
            e_ecnt = 0;
        end else if (!m_done) begin
            if (!s) begin
                acc = acc * 2 + longint'(d);
                run++;
                if (run == FL) begin
                    e_rw = 1'b0;
                    e_a  = AW'(acc >> DW);
                    e_d  = DW'(acc);
                    m_pkts++;
                    if (m_pkts == NP) m_done = 1'b1;
                    run = 0;
                    acc = 0;
                end
            end else if (run != 0) begin
                run   = 0;
                acc   = 0;
                e_err = 1'b1;
                if (e_ecnt < 15) e_ecnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("rw", 32'(RB2_RW), 32'(e_rw));
        chk("addr", 32'(RB2_A), 32'(e_a));
        chk("data", 32'(RB2_D), 32'(e_d));
        chk("done", 32'(done), 32'(m_done));
`ifdef S2_RX_ERR_EN
        chk("frame_err", 32'(frame_err), 32'(e_err));
        chk("err_cnt", 32'(err_cnt), 32'(e_ecnt));
`endif
    endtask

    task automatic send_frame(input logic [AW-1:0] a, input logic [DW-1:0] dat);
        logic [FL-1:0] f;
        f = {a, dat};
        for (int i = FL - 1; i >= 0; i--) step(1'b1, 1'b0, f[i]);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'($urandom));
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom));
    endtask

    initial begin
        // Reset, with sen low to show rst overrides the link.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        gap(2);

        // Single frame.
        send_frame(3'd5, 18'h2A5C3);
        gap(2);

        // Duplicate address; second write carries the new data.
        send_frame(3'd4, 18'h00001);
        gap(3);
        send_frame(3'd4, 18'h20000);
        gap(3);

        // Abort after 10 bits, then a full frame.
        partial(10);
        gap(1);
        send_frame(3'd2, 18'h3FFFF);
        gap(2);

        // Reset at bit 15, then a full frame.
        partial(14);
        step(1'b0, 1'b0, 1'b1);
        send_frame(3'd6, 18'h15555);
        gap(1);

        // Reset on the edge that would launch the write strobe.
        partial(20);
        step(1'b0, 1'b0, 1'b1);
        gap(1);
        send_frame(3'd3, 18'h0ABCD);
        gap(1);

        // Eight back-to-back frames with sen held low, then ignored traffic.
        step(1'b0, 1'b1, 1'b0);
        for (int a = 0; a < NP; a++) send_frame(AW'(a), DW'($urandom));
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom), 1'($urandom));

        // Random mix of frames, gaps and aborts until done.
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 60 && !m_done; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                partial(int'($urandom_range(1, FL - 1)));
                gap(int'($urandom_range(1, 3)));
            end
            send_frame(AW'($urandom), DW'($urandom));
            gap(int'($urandom_range(0, 3)));
        end
        gap(5);
        chk("final_done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
